memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Single-port RAM arbiter between the per-core instruction and data caches and main memory. It accepts word requests from every core's icache (read) and dcache (read/write), grants one at a time, drives the RAM port, and returns the RAM's completion as a one-cycle wait-low acknowledge to the granted requester. It sits directly upstream of the caches: its iwait/iload outputs are what an icache in UPDATE samples to fill a block.

## Interface
- CPUS, 2, number of cores; each has one icache and one dcache requester
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  CPUS  per-core icache read request, held until acknowledged
- iaddr  in  CPUS x 32  per-core icache word address
- iwait  out  CPUS  per-core icache wait; low for exactly one cycle = data valid on iload
- iload  out  CPUS x 32  per-core instruction data
- dREN, dWEN  in  CPUS each  per-core dcache read/write request (never both high)
- daddr, dstore  in  CPUS x 32 each  per-core dcache address / write data
- dwait  out  CPUS  per-core dcache wait, same semantics as iwait
- dload  out  CPUS x 32  per-core data-read data
- ramREN, ramWEN  out  1 each  RAM read/write enable
- ramaddr, ramstore  out  32 each  RAM address / write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR

## Operation
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE: if any request is pending, pick a winner and register it (grant index + type I/D); go to ACCESS next cycle. No request: stay.
- Priority: any dcache request beats any icache request. Within a class, core choice per Configuration.
- ACCESS: ramREN/ramWEN/ramaddr/ramstore driven combinationally from the granted requester's live inputs (requesters hold them stable). When ramstate == ACCESS: granted requester's wait is low this cycle; next state RELEASE. FREE/BUSY: stay. ERROR: stay, keep enables asserted (retry until ACCESS).
- RELEASE: all enables low, all waits high, no arbitration; next IDLE. This cycle absorbs the requester dropping its request, so a stale request is never re-granted.
- Granted requester withdraws request during ACCESS (illegal): return to IDLE next cycle, no acknowledge.
- iload[n] and dload[n] = ramload for all n (pass-through); valid only when the matching wait is low.
- Outside ACCESS: ramREN = ramWEN = 0, ramaddr = ramstore = 0.

## Timing
- Reset (async, any state including mid-ACCESS): state IDLE, grant cleared, all iwait/dwait = 1, ramREN = ramWEN = 0, ramaddr = ramstore = 0, round-robin pointer = core 0.
- Request visible in IDLE at cycle 0 -> RAM enables at cycle 1 -> wait low in the first cycle k ≥ 1 with ramstate == ACCESS -> RELEASE k+1 -> IDLE k+2. Back-to-back grant minimum spacing: 3 cycles.
- At most one wait output low in any cycle.
- Requests arriving while not in IDLE are held by the requester and seen at next IDLE.

## Configuration
- MEMORY_ARBITER_RR_EN defined: round-robin among cores within a class; pointer advances to (granted core + 1) mod CPUS on each acknowledge.
- Undefined: fixed priority, lowest core index wins; no pointer register.
- The dcache-over-icache rule holds either way.

## Structure
- ramstate_t, word_t, and CPUS default live in cpu_types_pkg; arb_state_t (IDLE/ACCESS/RELEASE) added there too.
- One sub-module: memory_arbiter_pick, combinational winner selection from request vectors and the round-robin pointer; the FSM, grant registers, and muxing stay in memory_arbiter.

## Test plan
- Reset, then a single iREN[0] at 0x0000_0040 with the RAM reporting ACCESS after 2 BUSY cycles -> ramREN=1, ramaddr=0x40 from cycle 1; iwait[0] low for exactly one cycle, in cycle 3, with iload[0]=ramload; IDLE by cycle 5.
- iREN[0] and dWEN[1] (daddr=0x80, dstore=0xDEADBEEF) raised in the same cycle -> dcache 1 served first with ramWEN=1, ramstore=0xDEADBEEF; icache 0 served 3+ cycles later.
- iREN[0] and iREN[1] held continuously, with zero-latency RAM -> with MEMORY_ARBITER_RR_EN, acks alternate 0,1,0,1; without it, core 0 is acked and core 1 waits until core 0 drops its request.
- ramstate ERROR for 3 cycles and then ACCESS during dREN[0] -> enables stay high throughout; a single dwait[0] low pulse occurs only on ACCESS.
- nRST asserted mid-ACCESS -> all waits immediately 1 and enables 0; after release, a pending request is regranted from IDLE.
- Requester holds iREN for one cycle after its ack -> RELEASE ignores it; no second ack.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, word type, default core count
// and the arbiter FSM state encoding.
package cpu_types_pkg;

  localparam int CPUS_DEFAULT = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // ARB_ prefix keeps these labels distinct from ramstate_t's ACCESS
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational winner selection: any dcache request beats any icache request;
// within a class the first requesting core at or after ptr (wrapping) wins.
module memory_arbiter_pick
  import cpu_types_pkg::*;
#(
  parameter int CPUS = CPUS_DEFAULT,
  parameter int IW   = idx_width(CPUS)
) (
  input  logic [CPUS-1:0] ireq,
  input  logic [CPUS-1:0] dreq,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic            is_d,
  output logic [IW-1:0]   idx
);

  logic          d_hit;
  logic          i_hit;
  logic [IW-1:0] d_idx;
  logic [IW-1:0] i_idx;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester overwrites last
  always_comb begin
    d_hit = 1'b0;
    i_hit = 1'b0;
    d_idx = '0;
    i_idx = '0;
    cand  = '0;
    for (int off = CPUS - 1; off >= 0; off--) begin
      cand  = IW'((int'(ptr) + off) % CPUS);
      d_hit = dreq[cand] ? 1'b1 : d_hit;
      d_idx = dreq[cand] ? cand : d_idx;
      i_hit = ireq[cand] ? 1'b1 : i_hit;
      i_idx = ireq[cand] ? cand : i_idx;
    end
  end

  assign valid = d_hit | i_hit;
  assign is_d  = d_hit;
  assign idx   = d_hit ? d_idx : i_idx;

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for per-core icache/dcache requesters.
// Define MEMORY_ARBITER_RR_EN for round-robin among cores; default is fixed priority.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = CPUS_DEFAULT,
  parameter int IW   = idx_width(CPUS)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  ramstate_t             ramstate
);

  arb_state_t    state;
  arb_state_t    state_next;
  logic          grant_d;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] rr_ptr;
  logic          pick_valid;
  logic          pick_d;
  logic [IW-1:0] pick_idx;
  logic          sel_ren;
  logic          sel_wen;
  word_t         sel_addr;
  word_t         sel_store;

  memory_arbiter_pick #(.CPUS(CPUS), .IW(IW)) u_pick (
    .ireq  (iREN),
    .dreq  (dREN | dWEN),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .is_d  (pick_d),
    .idx   (pick_idx)
  );

`ifdef MEMORY_ARBITER_RR_EN
  logic ack;

  assign ack = (state == ARB_ACCESS) && (sel_ren || sel_wen) && (ramstate == ACCESS);

  // Round-robin pointer moves past the core that was just acknowledged
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= '0;
    end else if (ack) begin
      rr_ptr <= (grant_idx == IW'(CPUS - 1)) ? '0 : grant_idx + IW'(1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // Live request lines of the granted requester; requesters hold them stable
  always_comb begin
    if (grant_d) begin
      sel_ren   = dREN[grant_idx];
      sel_wen   = dWEN[grant_idx];
      sel_addr  = daddr[grant_idx];
      sel_store = dstore[grant_idx];
    end else begin
      sel_ren   = iREN[grant_idx];
      sel_wen   = 1'b0;
      sel_addr  = iaddr[grant_idx];
      sel_store = '0;
    end
  end

  // Next state, RAM port drive and wait-low acknowledge
  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = '1;
    dwait      = '1;
    case (state)
      ARB_IDLE: begin
        state_next = pick_valid ? ARB_ACCESS : ARB_IDLE;
      end
      ARB_ACCESS: begin
        if (!(sel_ren || sel_wen)) begin
          state_next = ARB_IDLE;
        end else begin
          ramREN   = sel_ren;
          ramWEN   = sel_wen;
          ramaddr  = sel_addr;
          ramstore = sel_store;
          if (ramstate == ACCESS) begin
            state_next = ARB_RELEASE;
            if (grant_d) begin
              dwait[grant_idx] = 1'b0;
            end else begin
              iwait[grant_idx] = 1'b0;
            end
          end else begin
            state_next = ARB_ACCESS;
          end
        end
      end
      ARB_RELEASE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // State and grant registers; the grant is only captured on leaving IDLE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ARB_IDLE;
      grant_d   <= 1'b0;
      grant_idx <= '0;
    end else begin
      state <= state_next;
      if (state == ARB_IDLE && pick_valid) begin
        grant_d   <= pick_d;
        grant_idx <= pick_idx;
      end else begin
        grant_d   <= grant_d;
        grant_idx <= grant_idx;
      end
    end
  end

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int N = CPUS_DEFAULT;

  logic               CLK = 1'b0;
  logic               nRST;
  logic [N-1:0]       iREN;
  logic [N-1:0][31:0] iaddr;
  logic [N-1:0]       iwait;
  logic [N-1:0][31:0] iload;
  logic [N-1:0]       dREN;
  logic [N-1:0]       dWEN;
  logic [N-1:0][31:0] daddr;
  logic [N-1:0][31:0] dstore;
  logic [N-1:0]       dwait;
  logic [N-1:0][31:0] dload;
  logic               ramREN;
  logic               ramWEN;
  logic [31:0]        ramaddr;
  logic [31:0]        ramstore;
  logic [31:0]        ramload;
  ramstate_t          ramstate;

  memory_arbiter #(.CPUS(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          isd;
    bit          wr;
    int          core;
    logic [31:0] addr;
    logic [31:0] data;
    int          busy;
    bit          hold;
    bit          exp_ren;
    bit          exp_wen;
    logic [31:0] exp_store;
    int          exp_ack;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester id: dcache core c -> c, icache core c -> N+c (matches {iwait,dwait} bit)
  function automatic logic [2*N-1:0] wexp(input bit on, input int r);
    logic [2*N-1:0] w;
    w = '1;
    if (on) w[r] = 1'b0;
    return w;
  endfunction

  task automatic expect_out(input string tag, input logic ren, input logic wen,
                            input logic [31:0] addr, input logic [31:0] store,
                            input logic [2*N-1:0] w);
    chk(tag, {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore}, {w, ren, wen, addr, store});
  endtask

  task automatic expect_idle(input string tag);
    expect_out(tag, 1'b0, 1'b0, 32'h0, 32'h0, '1);
  endtask

  task automatic set_req(input bit isd, input bit wr, input int core,
                         input logic [31:0] addr, input logic [31:0] data, input bit on);
    if (isd) begin
      dREN[core]   = on & ~wr;
      dWEN[core]   = on & wr;
      daddr[core]  = addr;
      dstore[core] = data;
    end else begin
      iREN[core]  = on;
      iaddr[core] = addr;
    end
  endtask

  task automatic idle_inputs();
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    ramload = 32'h0; ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    #1 expect_idle("reset_state");
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int rid;
    rid = v.isd ? v.core : N + v.core;
    set_req(v.isd, v.wr, v.core, v.addr, v.data, 1'b1);
    ramstate = FREE;
    #1 expect_idle($sformatf("vec%0d_c0", i));
    @(negedge CLK);
    for (int c = 1; c <= v.busy + 1; c++) begin
      ramstate = (c <= v.busy) ? BUSY : ACCESS;
      ramload  = $urandom;
      #1 expect_out($sformatf("vec%0d_c%0d", i, c), v.exp_ren, v.exp_wen, v.addr,
                    v.exp_store, wexp(c == v.exp_ack, rid));
      if (c == v.exp_ack)
        chk($sformatf("vec%0d_load", i), v.isd ? dload[v.core] : iload[v.core], ramload);
      @(negedge CLK);
    end
    if (!v.hold) set_req(v.isd, v.wr, v.core, v.addr, v.data, 1'b0);
    ramstate = ACCESS;
    #1 expect_idle($sformatf("vec%0d_release", i));
    @(negedge CLK);
    set_req(v.isd, v.wr, v.core, v.addr, v.data, 1'b0);
    #1 expect_idle($sformatf("vec%0d_idle", i));
    @(negedge CLK);
    #1 expect_idle($sformatf("vec%0d_noregrant", i));
    @(negedge CLK);
  endtask

  vec_t tbl[6];
  int   acks[$];
  int   exp_acks[$];

  // Random-test reference model: flat requester list, one owner at a time,
  // a one-cycle gap after every acknowledge
  bit          act [2*N];
  bit          wr_m [2*N];
  logic [31:0] addr_m [2*N];
  logic [31:0] data_m [2*N];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 0, 32'h0000_0040, 32'h0, 2, 1'b0, 1'b1, 1'b0, 32'h0, 3};
    tbl[1] = '{1'b0, 1'b0, 1, 32'h0000_1000, 32'h0, 0, 1'b1, 1'b1, 1'b0, 32'h0, 1};
    tbl[2] = '{1'b1, 1'b0, 0, 32'h0000_0200, 32'h1234_5678, 1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 2};
    tbl[3] = '{1'b1, 1'b1, 1, 32'h0000_0080, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1};
    tbl[4] = '{1'b1, 1'b1, 0, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 3, 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A, 4};
    tbl[5] = '{1'b0, 1'b0, 1, 32'h0000_0000, 32'h0, 1, 1'b0, 1'b1, 1'b0, 32'h0, 2};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // dcache beats icache when both arrive together
    set_req(1'b0, 1'b0, 0, 32'h0000_0300, 32'h0, 1'b1);
    set_req(1'b1, 1'b1, 1, 32'h0000_0080, 32'hDEAD_BEEF, 1'b1);
    ramstate = FREE;
    #1 expect_idle("prio_c0");
    @(negedge CLK);
    ramstate = ACCESS;
    #1 expect_out("prio_d1_ack", 1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, wexp(1'b1, 1));
    @(negedge CLK);
    set_req(1'b1, 1'b1, 1, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0);
    #1 expect_idle("prio_release");
    @(negedge CLK);
    #1 expect_idle("prio_idle");
    @(negedge CLK);
    #1 expect_out("prio_i0_ack", 1'b1, 1'b0, 32'h300, 32'h0, wexp(1'b1, N + 0));
    @(negedge CLK);
    set_req(1'b0, 1'b0, 0, 32'h0000_0300, 32'h0, 1'b0);
    #1 expect_idle("prio_done");
    @(negedge CLK);

    // Two icache cores held continuously against a zero-latency RAM
    do_reset();
    set_req(1'b0, 1'b0, 0, 32'h0000_0010, 32'h0, 1'b1);
    set_req(1'b0, 1'b0, 1, 32'h0000_0020, 32'h0, 1'b1);
    ramstate = ACCESS;
    for (int c = 0; c < 12; c++) begin
      #1 chk("contend_onehot", 128'($countones(~{iwait, dwait}) <= 1), 128'(1));
      for (int k = 0; k < N; k++) if (!iwait[k]) acks.push_back(k);
      @(negedge CLK);
    end
`ifdef MEMORY_ARBITER_RR_EN
    exp_acks = '{0, 1, 0, 1};
`else
    exp_acks = '{0, 0, 0, 0};
`endif
    chk("contend_count", 128'(acks.size()), 128'(exp_acks.size()));
    for (int k = 0; k < exp_acks.size() && k < acks.size(); k++)
      chk($sformatf("contend_ack%0d", k), 128'(acks[k]), 128'(exp_acks[k]));
    acks.delete();
    iREN[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      for (int k = 0; k < N; k++) if (!iwait[k]) acks.push_back(k);
      @(negedge CLK);
      if (acks.size() > 0) iREN[1] = 1'b0;
    end
    chk("contend_drop_count", 128'(acks.size()), 128'(1));
    if (acks.size() > 0) chk("contend_drop_core", 128'(acks[0]), 128'(1));
    iREN = '0;

    // ERROR keeps the enables up; only ACCESS acknowledges
    set_req(1'b1, 1'b0, 0, 32'h0000_0500, 32'h0000_0077, 1'b1);
    ramstate = FREE;
    #1 expect_idle("err_c0");
    @(negedge CLK);
    for (int c = 1; c <= 3; c++) begin
      ramstate = ERROR;
      #1 expect_out($sformatf("err_c%0d", c), 1'b1, 1'b0, 32'h500, 32'h77, '1);
      @(negedge CLK);
    end
    ramstate = ACCESS;
    #1 expect_out("err_ack", 1'b1, 1'b0, 32'h500, 32'h77, wexp(1'b1, 0));
    @(negedge CLK);
    set_req(1'b1, 1'b0, 0, 32'h0000_0500, 32'h0000_0077, 1'b0);
    #1 expect_idle("err_release");
    @(negedge CLK);

    // Asynchronous reset in the middle of ACCESS, then regrant
    set_req(1'b0, 1'b0, 1, 32'h0000_0600, 32'h0, 1'b1);
    ramstate = FREE;
    #1 expect_idle("rst_c0");
    @(negedge CLK);
    ramstate = BUSY;
    #1 expect_out("rst_access", 1'b1, 1'b0, 32'h600, 32'h0, '1);
    nRST = 1'b0;
    #1 expect_idle("rst_async");
    @(negedge CLK);
    nRST = 1'b1;
    ramstate = ACCESS;
    #1 expect_idle("rst_idle");
    @(negedge CLK);
    #1 expect_out("rst_regrant", 1'b1, 1'b0, 32'h600, 32'h0, wexp(1'b1, N + 1));
    @(negedge CLK);
    set_req(1'b0, 1'b0, 1, 32'h0000_0600, 32'h0, 1'b0);
    #1 expect_idle("rst_release");
    @(negedge CLK);

    // Randomized traffic against the reference model
    do_reset();
    begin
      int owner;
      bit gap;
      int ptr;
      int just_acked;
      logic [2*N-1:0] w_e;
      logic ren_e, wen_e;
      logic [31:0] addr_e, store_e;
      owner = -1; gap = 1'b0; ptr = 0; just_acked = -1;
      for (int r = 0; r < 2 * N; r++) act[r] = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (just_acked >= 0) begin
          act[just_acked] = 1'b0;
          set_req(just_acked < N, wr_m[just_acked], just_acked % N,
                  addr_m[just_acked], data_m[just_acked], 1'b0);
          just_acked = -1;
        end
        for (int r = 0; r < 2 * N; r++) begin
          if (!act[r] && $urandom_range(0, 3) == 0) begin
            act[r]    = 1'b1;
            wr_m[r]   = (r < N) ? 1'($urandom_range(0, 1)) : 1'b0;
            addr_m[r] = $urandom;
            data_m[r] = $urandom;
            set_req(r < N, wr_m[r], r % N, addr_m[r], data_m[r], 1'b1);
          end
        end
        ramstate = ramstate_t'($urandom_range(0, 3));
        ramload  = $urandom;
        #1;
        w_e = '1; ren_e = 1'b0; wen_e = 1'b0; addr_e = 32'h0; store_e = 32'h0;
        if (gap) begin
          gap = 1'b0;
        end else if (owner < 0) begin
          for (int base = 0; base <= N && owner < 0; base += N)
            for (int k = 0; k < N && owner < 0; k++)
              if (act[base + (ptr + k) % N]) owner = base + (ptr + k) % N;
        end else begin
          ren_e   = (owner < N) ? ~wr_m[owner] : 1'b1;
          wen_e   = (owner < N) ? wr_m[owner] : 1'b0;
          addr_e  = addr_m[owner];
          store_e = (owner < N) ? data_m[owner] : 32'h0;
          if (ramstate == ACCESS) begin
            w_e[owner] = 1'b0;
            chk("rand_load", (owner < N) ? dload[owner % N] : iload[owner % N], ramload);
`ifdef MEMORY_ARBITER_RR_EN
            ptr = (owner % N + 1) % N;
`endif
            just_acked = owner;
            owner = -1;
            gap = 1'b1;
          end
        end
        expect_out($sformatf("rand_cyc%0d", cyc), ren_e, wen_e, addr_e, store_e, w_e);
        @(negedge CLK);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
